// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue/writeback controller.
//   DATA_WIDTH : default operand/result width of the ALU datapath.
//   OP_*       : 4-bit ALU opcode encodings. The controller passes them
//                through unchecked; they are named here for callers.
//   state_t    : controller FSM encoding (IDLE / EXEC / RESP).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int DATA_WIDTH = 16;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_ID   = 4'd2;
   localparam logic [3:0] OP_NAND = 4'd3;
   localparam logic [3:0] OP_NOR  = 4'd4;
   localparam logic [3:0] OP_XNOR = 4'd5;
   localparam logic [3:0] OP_NOT  = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_XOR  = 4'd9;
   localparam logic [3:0] OP_LRS  = 4'd10;
   localparam logic [3:0] OP_ARS  = 4'd11;
   localparam logic [3:0] OP_RR   = 4'd12;
   localparam logic [3:0] OP_LLS  = 4'd13;
   localparam logic [3:0] OP_ALS  = 4'd14;
   localparam logic [3:0] OP_RL   = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// Small register file feeding the ALU controller.
//   i_clk       : clock, write and clear on rising edge
//   i_rst_n     : synchronous active-low clear of every entry
//   i_we        : write enable
//   i_waddr     : write address
//   i_wdata     : write data
//   i_raddr1/2  : asynchronous read addresses (operands A/B)
//   o_rdata1/2  : asynchronous read data
//   i_dbg_addr  : debug read address
//   o_dbg_data  : asynchronous debug read data
// Clear has priority over a write in the same cycle, so a command that is
// in flight when reset arrives never lands in the array.
// -----------------------------------------------------------------------------
module alu_regfile #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_W     = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_W-1:0]     i_raddr1,
   input  logic [ADDR_W-1:0]     i_raddr2,
   input  logic [ADDR_W-1:0]     i_dbg_addr,
   output logic [DATA_WIDTH-1:0] o_rdata1,
   output logic [DATA_WIDTH-1:0] o_rdata2,
   output logic [DATA_WIDTH-1:0] o_dbg_data
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1   = r_mem[i_raddr1];
   assign o_rdata2   = r_mem[i_raddr2];
   assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
// Issue/writeback sequencer wrapped around a purely combinational 16-bit ALU.
// A command names source/destination registers of an internal register file;
// the controller latches operands, presents them to the ALU for one cycle,
// writes the result back and returns result/carry/zero on a response channel.
//
// Ports
//   CLK, RSTn            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake
//   cmd_op               : ALU opcode (passed through unchecked)
//   cmd_rd/rs1/rs2       : destination / source-A / source-B registers
//   cmd_use_imm, cmd_imm : take B from the immediate instead of rs2
//   alu_A/alu_B/alu_OP   : to the ALU, straight from the operand registers
//   alu_C/alu_Cout       : from the ALU
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data/cout/zero   : captured C, Cout and (C == 0)
//   dbg_addr/dbg_data    : combinational register-file peek
//
// Build option
//   ALU_CTRL_BACK2BACK_EN : when defined, a new command may be accepted in
//   RESP in the same cycle the response is taken, going straight to EXEC
//   (2-cycle issue interval). Undefined: commands only accepted in IDLE
//   (3-cycle issue interval).
// -----------------------------------------------------------------------------
module alu_ctrl #(
   parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
   parameter int REG_ADDR_W = 2
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [3:0]            cmd_op,
   input  logic [REG_ADDR_W-1:0] cmd_rd,
   input  logic [REG_ADDR_W-1:0] cmd_rs1,
   input  logic [REG_ADDR_W-1:0] cmd_rs2,
   input  logic                  cmd_use_imm,
   input  logic [DATA_WIDTH-1:0] cmd_imm,
   output logic [DATA_WIDTH-1:0] alu_A,
   output logic [DATA_WIDTH-1:0] alu_B,
   output logic [3:0]            alu_OP,
   input  logic [DATA_WIDTH-1:0] alu_C,
   input  logic                  alu_Cout,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_cout,
   output logic                  rsp_zero,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_data
);

   import alu_pkg::*;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_cmd_ready;
   logic                  w_rsp_valid;
   logic                  w_accept;
   logic                  w_wb_en;

   logic [DATA_WIDTH-1:0] w_rdata1;
   logic [DATA_WIDTH-1:0] w_rdata2;

   logic [DATA_WIDTH-1:0] r_opA;
   logic [DATA_WIDTH-1:0] r_opB;
   logic [3:0]            r_opOP;
   logic [REG_ADDR_W-1:0] r_rd;

   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_rsp_cout;
   logic                  r_rsp_zero;

   // Writeback happens at the edge that closes EXEC; the next command's
   // operand read (IDLE, or RESP in back-to-back mode) is always later, so
   // dependent commands never need forwarding.
   assign w_wb_en  = (r_state == EXEC);
   assign w_accept = cmd_valid && w_cmd_ready;

   alu_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (REG_ADDR_W)
   ) u_regfile (
      .i_clk      (CLK),
      .i_rst_n    (RSTn),
      .i_we       (w_wb_en),
      .i_waddr    (r_rd),
      .i_wdata    (alu_C),
      .i_raddr1   (cmd_rs1),
      .i_raddr2   (cmd_rs2),
      .i_dbg_addr (dbg_addr),
      .o_rdata1   (w_rdata1),
      .o_rdata2   (w_rdata2),
      .o_dbg_data (dbg_data)
   );

   // ---- FSM state register --------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---- FSM next state / handshake decode -----------------------------------
   // cmd_ready depends only on registered state (and rsp_ready in
   // back-to-back mode), never on cmd_valid.
   always_comb begin
      w_state_nxt = r_state;
      w_cmd_ready = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            w_state_nxt = RESP;
         end
         RESP: begin
            w_rsp_valid = 1'b1;
`ifdef ALU_CTRL_BACK2BACK_EN
            w_cmd_ready = rsp_ready;
            if (rsp_ready) begin
               w_state_nxt = cmd_valid ? EXEC : IDLE;
            end
`else
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
`endif
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign cmd_ready = w_cmd_ready;
   assign rsp_valid = w_rsp_valid;

   // ---- Issue stage: operand capture on accept ------------------------------
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_opA  <= '0;
         r_opB  <= '0;
         r_opOP <= 4'b0000;
         r_rd   <= '0;
      end else if (w_accept) begin
         r_opA  <= w_rdata1;
         r_opB  <= cmd_use_imm ? cmd_imm : w_rdata2;
         r_opOP <= cmd_op;
         r_rd   <= cmd_rd;
      end
   end

   assign alu_A  = r_opA;
   assign alu_B  = r_opB;
   assign alu_OP = r_opOP;

   // ---- Writeback stage: capture ALU result at the end of EXEC --------------
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_rsp_data <= '0;
         r_rsp_cout <= 1'b0;
         r_rsp_zero <= 1'b0;
      end else if (w_wb_en) begin
         r_rsp_data <= alu_C;
         r_rsp_cout <= alu_Cout;
         r_rsp_zero <= (alu_C == '0);
      end
   end

   assign rsp_data = r_rsp_data;
   assign rsp_cout = r_rsp_cout;
   assign rsp_zero = r_rsp_zero;

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- Issue/writeback sequencer directly upstream and downstream of the 16-bit ALU.
- Accepts a register-level command over a valid/ready handshake and reads operands from an internal 4x16 register file.
- Drives the ALU's A/B/OP inputs from registered operands, then captures C/Cout back into the destination register.
- Returns the result, carry and zero flags on a valid/ready response channel.

Parameters:
- DATA_WIDTH, 16, operand/result width; must match the ALU.
- REG_ADDR_W, 2, register-file address width; NUM_REGS = 2**REG_ADDR_W.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  4  ALU opcode.
- cmd_rd  in  REG_ADDR_W  destination register.
- cmd_rs1  in  REG_ADDR_W  source register for A.
- cmd_rs2  in  REG_ADDR_W  source register for B (ignored if cmd_use_imm).
- cmd_use_imm  in  1  B comes from cmd_imm.
- cmd_imm  in  DATA_WIDTH  immediate B operand.
- alu_A  out  DATA_WIDTH  to ALU A.
- alu_B  out  DATA_WIDTH  to ALU B.
- alu_OP  out  4  to ALU OP.
- alu_C  in  DATA_WIDTH  from ALU C.
- alu_Cout  in  1  from ALU Cout.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DATA_WIDTH  captured C.
- rsp_cout  out  1  captured Cout.
- rsp_zero  out  1  captured C == 0.
- dbg_addr  in  REG_ADDR_W  debug read address.
- dbg_data  out  DATA_WIDTH  combinational regfile[dbg_addr].

Behaviour:
- Clock/reset: one clock CLK. RSTn is synchronous and active-low: sampled only on the CLK rising edge, reset when 0.
- Reset values:
  - state = IDLE.
  - All regfile entries, operand registers, rsp_data, rsp_cout and rsp_zero = 0.
  - rsp_valid = 0; alu_OP = 4'b0000.
  - cmd_ready = 1 in the first cycle after reset deasserts.
- Reset mid-operation: in-flight command is discarded; no regfile write occurs in the reset cycle.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch opA = regfile[cmd_rs1], opB = (cmd_use_imm ? cmd_imm : regfile[cmd_rs2]), opOP = cmd_op, rdReg = cmd_rd.
  - Go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_A/alu_B/alu_OP driven from the operand registers; the ALU is purely combinational.
  - At the closing edge: regfile[rdReg] <= alu_C; rsp_data <= alu_C; rsp_cout <= alu_Cout; rsp_zero <= (alu_C == 0).
  - Go to RESP.
- RESP:
  - rsp_valid = 1; response fields held stable until the handshake.
  - On rsp_ready: go to IDLE.
  - Backpressure may hold RESP indefinitely; cmd_ready = 0 throughout.
- cmd_ready = (state == IDLE), a registered-state decode with no combinational path from cmd_valid.
- Latency: accept edge T; regfile updated at edge T+1; rsp_valid high from cycle T+1 onward. Minimum issue interval is 3 cycles.
- alu_A/alu_B/alu_OP always reflect the operand registers, stable outside EXEC too. Operand registers change only on accept.
- Hazards:
  - The next command's read occurs after the previous writeback, so a dependent command always sees the new value.
  - rs1 == rs2 == rd is legal.
- Widths: no truncation or extension; all datapaths are DATA_WIDTH. The opcode is passed through unchecked; all 16 encodings are legal.

Optional Feature:
- Macro: ALU_CTRL_BACK2BACK_EN.
- When defined:
  - In RESP, cmd_ready = rsp_ready.
  - A command and response handshake in the same cycle go RESP -> EXEC directly, giving a 2-cycle issue interval.
  - Operands for the new command are read in RESP, after the previous writeback, so no forwarding is needed.
- When undefined: behaviour exactly as above (3-cycle interval).

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams: OP_ADD=0, OP_SUB=1, OP_ID=2, OP_NAND=3, OP_NOR=4, OP_XNOR=5, OP_NOT=6, OP_AND=7, OP_OR=8, OP_XOR=9, OP_LRS=10, OP_ARS=11, OP_RR=12, OP_LLS=13, OP_ALS=14, OP_RL=15.
  - DATA_WIDTH constant.
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- One natural sub-module: alu_regfile.
  - 2 async read ports plus the debug read; 1 sync write port.
  - Synchronous active-low clear.

Test Plan:
- Reset, then read all dbg_addr -> every dbg_data = 0; cmd_ready = 1, rsp_valid = 0.
- Immediates:
  - imm 16'h0005 ADD into r1 (r0 = 0 as A) -> rsp_data = 5, rsp_cout = 0, rsp_zero = 0.
  - Then r1 + imm 16'hFFFB -> rsp_data = 0, rsp_cout = 1, rsp_zero = 1, dbg r2 = 0.
- Dependent chain:
  - r1 = 16'h8001 via ADD imm, then OP_ARS r1 -> r1; next cmd reads r1 -> sees shifted value.
  - rsp_valid first asserts exactly 1 cycle after accept.
- Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp fields stable, cmd_ready = 0, a second cmd_valid is not accepted; release -> IDLE next cycle.
- Reset mid-op: assert RSTn = 0 during EXEC -> regfile[rd] stays 0, rsp_valid = 0, state IDLE.
- With ALU_CTRL_BACK2BACK_EN: rsp_ready = 1 and cmd_valid held high -> accepts every 2 cycles and the second command sees the first result.
- Without ALU_CTRL_BACK2BACK_EN: same stimulus -> accepts every 3 cycles.
